// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button front end.
package key_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = 1_000_000;
  localparam int LONG_1S       = 50_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_e;

  // Normalise a synchronised pin to 1 = pressed.
  function automatic logic key_act(input logic pin, input logic active_low);
    if (active_low) begin
      return ~pin;
    end else begin
      return pin;
    end
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for slow board inputs; resets to the pin's idle level.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// Debounces one push-button and emits level plus press/release/long-press pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             pin_s;
  logic             act_s;
  key_state_e       state_r, state_s;
  logic [CNT_W-1:0] db_cnt_r, db_cnt_s;
  logic [CNT_W-1:0] long_cnt_r, long_cnt_s;
  logic             long_done_r, long_done_s;
  logic             press_s, release_s, long_s, level_s;

  key_sync #(.RST_VAL(KEY_ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (pin_s)
  );

  assign act_s = key_act(pin_s, KEY_ACTIVE_LOW);

  always_comb begin
    state_s     = state_r;
    db_cnt_s    = db_cnt_r;
    long_cnt_s  = long_cnt_r;
    long_done_s = long_done_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    long_s      = 1'b0;

    // Hold timer keeps running through release debounce so a bounce cannot restart it.
    if ((state_r == HELD) || (state_r == RELEASE_DB)) begin
      if (long_cnt_r == LONG_LAST) begin
        if (!long_done_r) begin
          long_s      = 1'b1;
          long_done_s = 1'b1;
        end else begin
          long_s      = 1'b0;
        end
      end else begin
        long_cnt_s = long_cnt_r + CNT_ONE;
      end
    end else begin
      long_cnt_s = long_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (act_s) begin
          state_s  = PRESS_DB;
          db_cnt_s = CNT_ZERO;
        end else begin
          state_s  = IDLE;
        end
      end
      PRESS_DB: begin
        if (!act_s) begin
          state_s = IDLE;
        end else if (db_cnt_r == DB_LAST) begin
          state_s     = HELD;
          press_s     = 1'b1;
          long_cnt_s  = CNT_ZERO;
          long_done_s = 1'b0;
        end else begin
          db_cnt_s = db_cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!act_s) begin
          state_s  = RELEASE_DB;
          db_cnt_s = CNT_ZERO;
        end else begin
          state_s  = HELD;
        end
      end
      RELEASE_DB: begin
        if (act_s) begin
          state_s = HELD;
        end else if (db_cnt_r == DB_LAST) begin
          state_s   = IDLE;
          release_s = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    level_s = (state_s == HELD) || (state_s == RELEASE_DB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      db_cnt_r    <= CNT_ZERO;
      long_cnt_r  <= CNT_ZERO;
      long_done_r <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state_r     <= state_s;
      db_cnt_r    <= db_cnt_s;
      long_cnt_r  <= long_cnt_s;
      long_done_r <= long_done_s;
      key_level   <= level_s;
      key_press   <= press_s;
      key_release <= release_s;
      key_long    <= long_s;
    end
  end

endmodule
